// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks with 0x80/zero/length padding.
// Optional SHA_PAD_OVF_EN adds a sticky o_ovf flag for block-index wrap within one message.
module sha256_msg_padder #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             s_zero,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [511:0]     m_block,
  output logic             m_last,
  output logic [CNT_W-1:0] m_idx
`ifdef SHA_PAD_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  typedef enum logic [1:0] {FILL, PAD1, PAD2, OUT} state_t;

  state_t           state_reg, state_next;
  logic [6:0]       ptr_reg, ptr_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [CNT_W-1:0] idx_reg, idx_next;
  logic             last_reg, last_next;
  logic             fin_reg, fin_next;
  logic             need2_reg, need2_next;
  logic [511:0]     blk_reg, blk_next;
  logic [63:0]      len64;
  logic [7:0]       len_byte [64];
  logic             beat;
  logic             data_beat;

  assign len64     = 64'(len_reg);
  assign s_ready   = (state_reg == FILL) & rst_n;
  assign beat      = s_valid & s_ready;
  assign data_beat = beat & ~s_zero;

  assign m_valid = (state_reg == OUT);
  assign m_block = blk_reg;
  assign m_last  = last_reg;
  assign m_idx   = idx_reg;

  // Per-byte lane of the block buffer; the length field lives in lanes 56..63, MSB first.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_lane
      logic [7:0] cur_b;
      logic [7:0] nxt_b;

      if (gi >= 56) begin : g_len
        assign len_byte[gi] = len64[8*(63-gi) +: 8];
      end else begin : g_nolen
        assign len_byte[gi] = 8'h00;
      end

      assign cur_b = blk_reg[511-8*gi -: 8];

      always_comb begin
        nxt_b = cur_b;
        case (state_reg)
          FILL: begin
            if (data_beat && (ptr_reg == 7'(gi))) nxt_b = s_data;
          end
          PAD1: begin
            if (ptr_reg == 7'(gi))
              nxt_b = 8'h80;
            else if (7'(gi) > ptr_reg)
              nxt_b = (ptr_reg <= 7'd55) ? len_byte[gi] : 8'h00;
          end
          PAD2: nxt_b = len_byte[gi];
          default: ;
        endcase
      end

      assign blk_next[511-8*gi -: 8] = nxt_b;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    fin_next   = fin_reg;
    need2_next = need2_reg;
    case (state_reg)
      FILL: begin
        if (beat) begin
          if (s_zero) begin
            // A zero beat without s_last carries nothing and is simply dropped.
            if (s_last) state_next = PAD1;
          end else begin
            ptr_next = ptr_reg + 7'd1;
            len_next = len_reg + LEN_W'(8);
            if (ptr_reg == 7'd63) begin
              state_next = OUT;
              last_next  = 1'b0;
              fin_next   = s_last;
            end else if (s_last) begin
              state_next = PAD1;
            end
          end
        end
      end
      PAD1: begin
        if (ptr_reg <= 7'd55) begin
          last_next = 1'b1;
        end else begin
          last_next  = 1'b0;
          need2_next = 1'b1;
        end
        state_next = OUT;
      end
      PAD2: begin
        last_next  = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        if (m_ready) begin
          if (last_reg) begin
            len_next   = '0;
            ptr_next   = '0;
            idx_next   = '0;
            fin_next   = 1'b0;
            need2_next = 1'b0;
            last_next  = 1'b0;
            state_next = FILL;
          end else if (fin_reg) begin
            // Message ended exactly on a block boundary: next block is pure padding.
            fin_next   = 1'b0;
            ptr_next   = '0;
            idx_next   = idx_reg + CNT_W'(1);
            state_next = PAD1;
          end else if (need2_reg) begin
            need2_next = 1'b0;
            idx_next   = idx_reg + CNT_W'(1);
            state_next = PAD2;
          end else begin
            ptr_next   = '0;
            idx_next   = idx_reg + CNT_W'(1);
            state_next = FILL;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FILL;
      ptr_reg   <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      last_reg  <= 1'b0;
      fin_reg   <= 1'b0;
      need2_reg <= 1'b0;
      blk_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      fin_reg   <= fin_next;
      need2_reg <= need2_next;
      blk_reg   <= blk_next;
    end
  end

`ifdef SHA_PAD_OVF_EN
  logic ovf_reg, ovf_next;
  logic in_msg_reg, in_msg_next;
  logic idx_inc;

  assign idx_inc = (state_reg == OUT) & m_ready & ~last_reg;
  assign o_ovf   = ovf_reg;

  always_comb begin
    ovf_next    = ovf_reg;
    in_msg_next = in_msg_reg;
    if (beat && !in_msg_reg) begin
      ovf_next    = 1'b0;
      in_msg_next = 1'b1;
    end
    if (idx_inc && (idx_reg == '1)) ovf_next = 1'b1;
    if ((state_reg == OUT) && m_ready && last_reg) in_msg_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg    <= 1'b0;
      in_msg_reg <= 1'b0;
    end else begin
      ovf_reg    <= ovf_next;
      in_msg_reg <= in_msg_next;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: padding model feeds an expected-block queue, monitor pops on transfer.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid, s_ready, s_last, s_zero;
  logic [7:0]   s_data;
  logic         m_valid, m_ready, m_last;
  logic [511:0] m_block;
  logic [7:0]   m_idx;

  always #5 clk = ~clk;

  sha256_msg_padder #(.CNT_W(8), .LEN_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_zero(s_zero),
    .m_valid(m_valid), .m_ready(m_ready), .m_block(m_block), .m_last(m_last), .m_idx(m_idx)
  );

  typedef struct {
    logic [511:0] blk;
    logic         last;
    logic [7:0]   idx;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   msg[$];
  int           checks = 0;
  int           failures = 0;
  int           rdy_mode = 0;
  logic [511:0] last_blk_seen = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic push_expected();
    logic [7:0]      p[$];
    longint unsigned bits;
    int              nb;
    exp_t            e;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = longint'(msg.size()) * 8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int k = 0; k < 64; k++) e.blk[511-8*k -: 8] = p[64*b+k];
      e.last = (b == nb - 1);
      e.idx  = 8'(b);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic zero);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_zero  = zero;
    while (!s_ready && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) begin
      checks++;
      failures++;
      $display("FAIL s_ready_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_zero  = 1'b0;
  endtask

  task automatic send_msg(input bit zero_end, input bit gaps);
    push_expected();
    for (int i = 0; i < msg.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      if (gaps && $urandom_range(0, 7) == 0) send_beat(8'($urandom), 1'b0, 1'b1);
      send_beat(msg[i], (i == msg.size() - 1) && !zero_end, 1'b0);
    end
    if (msg.size() == 0 || zero_end) send_beat(8'h00, 1'b1, 1'b1);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // m_ready driver: 0 = always ready, 1 = random, 2 = stall each block for 10 cycles.
  initial begin
    int wait_cnt = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: begin
          if (!m_valid) begin
            wait_cnt = 0;
            m_ready  = 1'b0;
          end else if (wait_cnt < 10) begin
            wait_cnt++;
            m_ready = 1'b0;
          end else begin
            m_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: pops and compares on every output transfer, checks hold stability while stalled.
  initial begin
    logic         hold = 1'b0;
    logic [511:0] h_blk;
    logic         h_last;
    logic [7:0]   h_idx;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else if (m_valid) begin
        if (hold) begin
          chk("hold_block", m_block, h_blk);
          chk("hold_last", 512'(m_last), 512'(h_last));
          chk("hold_idx", 512'(m_idx), 512'(h_idx));
        end
        if (m_ready) begin
          hold = 1'b0;
          last_blk_seen = m_block;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_block actual=%0h required=none", m_block);
          end else begin
            e = exp_q.pop_front();
            $display("block idx=%0d last=%0b data=%0h", m_idx, m_last, m_block);
            chk("block_data", m_block, e.blk);
            chk("block_last", 512'(m_last), 512'(e.last));
            chk("block_idx", 512'(m_idx), 512'(e.idx));
            chk("s_ready_low_in_out", 512'(s_ready), 512'(0));
          end
        end else begin
          hold   = 1'b1;
          h_blk  = m_block;
          h_last = m_last;
          h_idx  = m_idx;
        end
      end else begin
        if (hold) begin
          checks++;
          failures++;
          $display("FAIL valid_dropped actual=0 required=1");
        end
        hold = 1'b0;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 512'(m_valid), 512'(0));
    chk({tag, "_m_block"}, m_block, 512'(0));
    chk({tag, "_m_last"}, 512'(m_last), 512'(0));
    chk({tag, "_m_idx"}, 512'(m_idx), 512'(0));
    chk({tag, "_s_ready"}, 512'(s_ready), 512'(0));
  endtask

  task automatic load_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  task automatic load_seq(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'(i));
  endtask

  initial begin
    logic [511:0] abc_const;
    abc_const = {32'h61626380, 416'h0, 64'h18};
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    s_zero  = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s_ready_after_reset", 512'(s_ready), 512'(1));

    // "abc": final block 2 cycles after the s_last beat.
    load_abc();
    send_msg(1'b0, 1'b0);
    chk("abc_latency_c1", 512'(m_valid), 512'(0));
    @(posedge clk); #1;
    chk("abc_latency_c2", 512'(m_valid), 512'(1));
    drain();
    chk("abc_const", last_blk_seen, abc_const);

    msg.delete();
    send_msg(1'b0, 1'b0);
    drain();
    chk("empty_const", last_blk_seen, {8'h80, 504'h0});

    load_seq(55);
    send_msg(1'b0, 1'b0);
    drain();
    chk("len55_field", 512'(last_blk_seen[63:0]), 512'(64'h1B8));

    load_seq(56);
    send_msg(1'b0, 1'b0);
    drain();
    chk("len56_field", 512'(last_blk_seen[63:0]), 512'(64'h1C0));

    // 64 bytes: full data block appears 1 cycle after the last byte.
    load_seq(64);
    send_msg(1'b0, 1'b0);
    chk("full_block_latency", 512'(m_valid), 512'(1));
    drain();
    chk("len64_const", last_blk_seen, {8'h80, 440'h0, 64'h200});

    // 64 bytes then a separate zero beat ends the message on a block boundary.
    load_seq(64);
    send_msg(1'b1, 1'b0);
    drain();

    rdy_mode = 2;
    load_seq(56);
    send_msg(1'b0, 1'b0);
    drain();
    rdy_mode = 0;

    // Reset mid-message discards 20 bytes; nothing may be emitted for them.
    for (int i = 0; i < 20; i++) send_beat(8'(i + 8'hA0), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midmsg_reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_abc();
    send_msg(1'b0, 1'b0);
    drain();
    chk("abc_after_reset", last_blk_seen, abc_const);

    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(0, 150);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      send_msg(1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
